// File: rtl/i2c_init_seq.sv
// -----------------------------------------------------------------------------
// i2c_init_seq
//
// Table-driven I2C initialisation sequencer. It walks an external
// table of 12-bit entries {op[11:8], arg[7:0]} starting at entry 0 and turns
// them into commands and write data for an AXI-stream style I2C master
// (command channel + data channel).
//
// Opcodes:
//   0x0 END        finish: one-cycle done pulse, back to idle
//   0x1 ADDR       latch arg[6:0] as the I2C device address
//   0x2 START_WR   issue one command: start + write_multiple + stop
//   0x3 DATA       push arg as a write byte, tlast = 0
//   0x4 DATA_LAST  push arg as a write byte, tlast = 1
//   0x5 DELAY      wait (arg << DELAY_SHIFT) cycles
//   0x6 JUMP       continue at entry arg
//   0x7-0xF        invalid: sticky error, done pulse, back to idle
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start                      begin a sequence at entry 0 (ignored while busy)
//   table_addr / table_data    external table; data valid one cycle after addr
//   m_axis_cmd_*               command channel to the I2C master
//   m_axis_data_*              write-data stream to the I2C master
//   busy                       sequence in progress
//   done                       one-cycle pulse when a sequence ends
//   error                      last sequence hit an invalid opcode
// -----------------------------------------------------------------------------
module i2c_init_seq #(
    parameter int TABLE_AW    = 8,
    parameter int DELAY_SHIFT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,

    output logic [TABLE_AW-1:0] table_addr,
    input  logic [11:0]         table_data,

    output logic [6:0]          m_axis_cmd_address,
    output logic                m_axis_cmd_start,
    output logic                m_axis_cmd_read,
    output logic                m_axis_cmd_write,
    output logic                m_axis_cmd_write_multiple,
    output logic                m_axis_cmd_stop,
    output logic                m_axis_cmd_valid,
    input  logic                m_axis_cmd_ready,

    output logic [7:0]          m_axis_data_tdata,
    output logic                m_axis_data_tvalid,
    input  logic                m_axis_data_tready,
    output logic                m_axis_data_tlast,

    output logic                busy,
    output logic                done,
    output logic                error
);

    // Delay counter must hold the largest arg << DELAY_SHIFT.
    localparam int CNT_W = 8 + DELAY_SHIFT;

    localparam logic [3:0] OP_END       = 4'h0;
    localparam logic [3:0] OP_ADDR      = 4'h1;
    localparam logic [3:0] OP_START_WR  = 4'h2;
    localparam logic [3:0] OP_DATA      = 4'h3;
    localparam logic [3:0] OP_DATA_LAST = 4'h4;
    localparam logic [3:0] OP_DELAY     = 4'h5;
    localparam logic [3:0] OP_JUMP      = 4'h6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,    // table_addr presented, table read in flight
        ST_DECODE,   // table_data valid, entry is executed
        ST_CMD,      // command held until m_axis_cmd_ready
        ST_DATA,     // write byte held until m_axis_data_tready
        ST_DELAY     // counting down a DELAY entry
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [TABLE_AW-1:0] r_table_addr;
    logic [6:0]          r_dev_addr;
    logic [7:0]          r_tdata;
    logic                r_tlast;
    logic [CNT_W-1:0]    r_delay_cnt;
    logic                r_done;
    logic                r_error;

    logic [3:0]          w_op;
    logic [7:0]          w_arg;
    logic [CNT_W-1:0]    w_delay_len;

    assign w_op        = table_data[11:8];
    assign w_arg       = table_data[7:0];
    assign w_delay_len = CNT_W'(w_arg) << DELAY_SHIFT;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block purely
    // combinational; without it an unlisted path would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    OP_END:                w_state_next = ST_IDLE;
                    OP_ADDR:               w_state_next = ST_FETCH;
                    OP_START_WR:           w_state_next = ST_CMD;
                    OP_DATA, OP_DATA_LAST: w_state_next = ST_DATA;
                    // A zero-length delay skips the DELAY state entirely.
                    OP_DELAY:              w_state_next = (w_arg == 8'd0) ? ST_FETCH : ST_DELAY;
                    OP_JUMP:               w_state_next = ST_FETCH;
                    default:               w_state_next = ST_IDLE;
                endcase
            end
            ST_CMD: begin
                if (m_axis_cmd_ready) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_DATA: begin
                if (m_axis_data_tready) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_DELAY: begin
                // Counter was loaded with the full length, so leaving on 1
                // spends exactly that many cycles here.
                if (r_delay_cnt == CNT_W'(1)) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: table pointer, device address, data byte, delay,
    // done pulse and sticky error.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_table_addr <= '0;
            r_dev_addr   <= '0;
            r_tdata      <= '0;
            r_tlast      <= 1'b0;
            r_delay_cnt  <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_table_addr <= '0;
                        r_error      <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    // The pointer moves on while the entry executes; it is
                    // only presented to the table again in FETCH.
                    if (w_op == OP_JUMP) begin
                        r_table_addr <= TABLE_AW'(w_arg);
                    end else begin
                        r_table_addr <= r_table_addr + TABLE_AW'(1);
                    end
                    case (w_op)
                        OP_END: begin
                            r_done <= 1'b1;
                        end
                        OP_ADDR: begin
                            r_dev_addr <= w_arg[6:0];
                        end
                        OP_DATA, OP_DATA_LAST: begin
                            r_tdata <= w_arg;
                            r_tlast <= (w_op == OP_DATA_LAST);
                        end
                        OP_DELAY: begin
                            r_delay_cnt <= w_delay_len;
                        end
                        OP_START_WR, OP_JUMP: begin
                        end
                        default: begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    endcase
                end
                ST_DELAY: begin
                    r_delay_cnt <= r_delay_cnt - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic. Valids decode straight from the state register, so the
    // command and data channels are mutually exclusive by construction and
    // both drop immediately on reset.
    // -------------------------------------------------------------------------
    always_comb begin
        busy                      = (r_state != ST_IDLE);
        table_addr                = r_table_addr;

        m_axis_cmd_valid          = (r_state == ST_CMD);
        m_axis_cmd_address        = r_dev_addr;
        m_axis_cmd_start          = (r_state == ST_CMD);
        m_axis_cmd_write_multiple = (r_state == ST_CMD);
        m_axis_cmd_stop           = (r_state == ST_CMD);
        m_axis_cmd_read           = 1'b0;
        m_axis_cmd_write          = 1'b0;

        m_axis_data_tvalid        = (r_state == ST_DATA);
        m_axis_data_tdata         = r_tdata;
        m_axis_data_tlast         = r_tlast && (r_state == ST_DATA);

        done                      = r_done;
        error                     = r_error;
    end

endmodule

// File: doc/i2c_init_seq.md
I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

Interface
REQ-001 SHALL have parameter TABLE_AW, default 8: table address width (table depth 2^TABLE_AW entries).
REQ-002 SHALL have parameter DELAY_SHIFT, default 4: delay scale, wait cycles = arg << DELAY_SHIFT.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin sequence at entry 0.
REQ-006 SHALL have port table_addr  output  TABLE_AW  external table read address.
REQ-007 SHALL have port table_data  input  12  entry {op[11:8], arg[7:0]}, valid one cycle after table_addr.
REQ-008 SHALL have port m_axis_cmd_address  output  7  I2C device address.
REQ-009 SHALL have ports m_axis_cmd_start, _read, _write, _write_multiple, _stop  output  1 each  command flags.
REQ-010 SHALL have ports m_axis_cmd_valid output 1 and m_axis_cmd_ready input 1: command handshake.
REQ-011 SHALL have ports m_axis_data_tdata output 8, m_axis_data_tvalid output 1, m_axis_data_tready input 1, m_axis_data_tlast output 1: write data stream.
REQ-012 SHALL have port busy  output  1  sequence in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at sequence end.
REQ-014 SHALL have port error  output  1  sequence aborted on invalid opcode.

Function
REQ-015 SHALL use states IDLE, FETCH, DECODE, CMD, DATA, DELAY; FETCH presents table_addr, DECODE consumes table_data.
REQ-016 SHALL, in IDLE with start=1, set table_addr=0, clear error, go FETCH; busy=1 from the next cycle.
REQ-017 SHALL ignore start whenever busy=1.
REQ-018 SHALL implement op 0x0 END: done=1 for one cycle, busy=0, return IDLE.
REQ-019 SHALL implement op 0x1 ADDR: latch arg[6:0] as device address, advance entry, no bus activity.
REQ-020 SHALL implement op 0x2 START_WR: assert cmd_valid with address=latched, start=1, write_multiple=1, stop=1, read=0, write=0; hold all stable until cmd_ready=1.
REQ-021 SHALL implement op 0x3 DATA and 0x4 DATA_LAST: tvalid=1, tdata=arg, tlast=(op==0x4); hold stable until tready=1.
REQ-022 SHALL implement op 0x5 DELAY: wait exactly arg<<DELAY_SHIFT cycles in DELAY before next FETCH; arg=0 gives zero wait cycles.
REQ-023 SHALL implement op 0x6 JUMP: next table_addr = arg, zero-extended or truncated to TABLE_AW.
REQ-024 SHALL treat ops 0x7-0xF as invalid: error=1 (sticky until next accepted start), done pulse, busy=0, IDLE.
REQ-025 SHALL advance table_addr by 1 after every non-JUMP entry, wrapping from 2^TABLE_AW-1 to 0.
REQ-026 SHALL never assert cmd_valid and tvalid in the same cycle; cmd_valid/tvalid drop the cycle after handshake.
REQ-027 SHALL take 2 cycles (FETCH+DECODE) per ADDR/JUMP entry; CMD/DATA add one cycle minimum when ready is high.
REQ-028 SHALL keep the latched device address across JUMP and across sequences until reset.

Reset
REQ-029 SHALL, on rst_n=0, immediately force IDLE, table_addr=0, device address=0, all cmd flags/valid=0, tdata=0, tvalid=0, tlast=0, busy=0, done=0, error=0.
REQ-030 SHALL resume operation only on a start after rst_n returns high; reset mid-handshake discards the transfer.

Verification
REQ-031 SHALL pass: table {0x150, 0x200, 0x312, 0x434, 0x000}, ready=1 -> one cmd addr 0x50 start/wm/stop, data 0x12 tlast 0, 0x34 tlast 1, done pulse, error 0.
REQ-032 SHALL pass: same table, tready=0 for 5 cycles on first byte -> tdata held 0x12, tvalid held 1, no byte lost or duplicated.
REQ-033 SHALL pass: entry 0x503 with DELAY_SHIFT=4 -> exactly 48 cycles in DELAY before next FETCH.
REQ-034 SHALL pass: entry 0xA00 -> error=1, done pulse, busy=0; next start clears error.
REQ-035 SHALL pass: rst_n low during DATA with tvalid=1 -> tvalid, busy go 0 asynchronously; next start refetches entry 0.
REQ-036 SHALL pass: table {0x605, ..., entry 5 = 0x000}, start pulsed while busy -> jump to 5, single done pulse, second start ignored.
